tone_synth_pwm: RTL and testbench



---
 rtl/tone_synth_pwm_if.sv | 19 +
 rtl/tone_synth_pwm.sv | 141 ++++++++++++++
 tb/tb_tone_synth_pwm.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_synth_pwm_if.sv
// Amplifier header pins driven by the tone synthesiser.
// The master side drives the amp; the slave side observes it.
interface tone_synth_pwm_if;
   logic AIN;
   logic GAIN;
   logic SHUTDOWN_L;

   modport master (
      output AIN,
      output GAIN,
      output SHUTDOWN_L
   );

   modport slave (
      input AIN,
      input GAIN,
      input SHUTDOWN_L
   );
endinterface

// File: rtl/tone_synth_pwm.sv
// Key-selected square-wave tone, PWM-modulated by a ramped
// volume envelope, driving the audio amp pins directly.
module tone_synth_pwm #(
   parameter int NUM_KEYS = 4,
   parameter int TONE_W = 10,
   parameter logic [NUM_KEYS*TONE_W-1:0] TONE_TABLE =
      {10'd747, 10'd498, 10'd593, 10'd665},
   parameter int VOL_W = 8,
   parameter int MODE = 0,
   parameter int ENV_EN = 1,
   parameter int RAMP_DIV = 256,
   parameter int AUTO_SHDN = 1,
   localparam int IW = $clog2(NUM_KEYS > 1 ? NUM_KEYS : 2),
   localparam int RW = $clog2(RAMP_DIV > 1 ? RAMP_DIV : 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic [VOL_W-1:0]    volume,
   input  logic                gain_hi,
   output logic                note_active,
   output logic [IW-1:0]       note_idx,
   tone_synth_pwm_if.master    amp
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t state, state_nxt;

   logic [NUM_KEYS-1:0] ks1, ks2;
   logic [IW-1:0]       pick, idx_nxt;
   logic [TONE_W-1:0]   cnt, half;
   logic                phase;
   logic [VOL_W-1:0]    pcnt, level, level_nxt;
   logic [RW-1:0]       rcnt;
   logic                tick, restart, silent;

   assign note_active = (state == HOLD);

   always_comb begin
      pick = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (ks2[i]) pick = IW'(i);
   end

   // MODE 0 latches one key; MODE 1 re-picks every cycle
   always_comb begin
      state_nxt = state;
      idx_nxt   = note_idx;
      if (MODE != 0) begin
         state_nxt = (|ks2) ? HOLD : IDLE;
         if (|ks2) idx_nxt = pick;
      end else begin
         unique case (state)
            IDLE: if (|ks2) begin
               state_nxt = HOLD;
               idx_nxt   = pick;
            end
            HOLD: if (!ks2[note_idx]) state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ks1      <= '0;
         ks2      <= '0;
         state    <= IDLE;
         note_idx <= '0;
      end else begin
         ks1      <= keys;
         ks2      <= ks1;
         state    <= state_nxt;
         note_idx <= idx_nxt;
      end
   end

   assign half    = TONE_TABLE[int'(note_idx) * TONE_W +: TONE_W];
   assign restart = (state_nxt == HOLD) &&
                    (state == IDLE || idx_nxt != note_idx);
   assign silent  = (state == IDLE) && (level == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (restart) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (silent) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == half - 1'b1) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (rcnt == RW'(RAMP_DIV - 1));

   // Level steps one unit per tick and saturates at the target
   always_comb begin
      level_nxt = level;
      if (ENV_EN == 0) begin
         level_nxt = note_active ? volume : '0;
      end else if (tick) begin
         if (note_active && level < volume)
            level_nxt = level + 1'b1;
         else if (note_active && level > volume)
            level_nxt = level - 1'b1;
         else if (!note_active && level != '0)
            level_nxt = level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt           <= '0;
         rcnt           <= '0;
         level          <= '0;
         amp.AIN        <= 1'b0;
         amp.GAIN       <= 1'b0;
         amp.SHUTDOWN_L <= 1'b1;
      end else begin
         pcnt           <= pcnt + 1'b1;
         rcnt           <= tick ? '0 : rcnt + 1'b1;
         level          <= level_nxt;
         amp.AIN        <= phase & (pcnt < level);
         amp.GAIN       <= gain_hi;
         amp.SHUTDOWN_L <= (AUTO_SHDN == 0) ||
                           (state_nxt == HOLD) ||
                           (level != '0);
      end
   end

endmodule

// File: tb/tb_tone_synth_pwm.sv
// Directed bench for tone_synth_pwm: hold vs priority select,
// envelope ramps, PWM duty, release tail and auto shutdown.
module tb_tone_synth_pwm;

   localparam logic [39:0] TT = {10'd4, 10'd6, 10'd8, 10'd10};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] keys = '0;
   logic [3:0] volume = '0;
   logic       gain_hi = 1'b0;

   logic       na0, na1, na2;
   logic [1:0] idx0, idx1, idx2;

   int n_pass = 0;
   int n_total = 0;

   tone_synth_pwm_if amp0 ();
   tone_synth_pwm_if amp1 ();
   tone_synth_pwm_if amp2 ();

   tone_synth_pwm #(
      .NUM_KEYS(4), .TONE_W(10), .TONE_TABLE(TT), .VOL_W(4),
      .MODE(0), .ENV_EN(1), .RAMP_DIV(2), .AUTO_SHDN(1)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .keys(keys), .volume(volume),
      .gain_hi(gain_hi), .note_active(na0), .note_idx(idx0),
      .amp(amp0.master)
   );

   tone_synth_pwm #(
      .NUM_KEYS(4), .TONE_W(10), .TONE_TABLE(TT), .VOL_W(4),
      .MODE(1), .ENV_EN(1), .RAMP_DIV(2), .AUTO_SHDN(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .keys(keys), .volume(volume),
      .gain_hi(gain_hi), .note_active(na1), .note_idx(idx1),
      .amp(amp1.master)
   );

   tone_synth_pwm #(
      .NUM_KEYS(4), .TONE_W(10), .TONE_TABLE(TT), .VOL_W(4),
      .MODE(0), .ENV_EN(0), .RAMP_DIV(2), .AUTO_SHDN(1)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .keys(keys), .volume(volume),
      .gain_hi(gain_hi), .note_active(na2), .note_idx(idx2),
      .amp(amp2.master)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      keys  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic e;
      rst_n   = 1'b0;
      keys    = 4'b1111;
      gain_hi = 1'b1;
      volume  = 4'd15;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({na0, idx0, amp0.AIN, amp0.GAIN, amp0.SHUTDOWN_L}
             !== 6'b000001)
            $display("FAIL rst_hold%0d: got %b want 000001", i,
               {na0, idx0, amp0.AIN, amp0.GAIN, amp0.SHUTDOWN_L});
         else n_pass++;
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         e = (k >= 3);
         n_total++;
         if (na0 !== e)
            $display("FAIL rst_na k=%0d: got %b want %b", k, na0, e);
         else n_pass++;
         n_total++;
         if (amp0.AIN !== 1'b0)
            $display("FAIL rst_ain k=%0d: got %b want 0", k, amp0.AIN);
         else n_pass++;
         e = (k <= 3);
         n_total++;
         if (amp0.GAIN !== e)
            $display("FAIL rst_gain k=%0d: got %b want %b",
               k, amp0.GAIN, e);
         else n_pass++;
         e = (k >= 3);
         n_total++;
         if (amp0.SHUTDOWN_L !== e)
            $display("FAIL rst_shdn k=%0d: got %b want %b",
               k, amp0.SHUTDOWN_L, e);
         else n_pass++;
         if (k == 3) begin
            n_total++;
            if (idx0 !== 2'd0)
               $display("FAIL rst_idx: got %0d want 0", idx0);
            else n_pass++;
            gain_hi = 1'b0;
         end
      end
   endtask

   task automatic test_tone_env();
      logic e;
      do_reset();
      keys   = 4'b0010;
      volume = 4'd15;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 2) begin
            n_total++;
            if (na0 !== 1'b0)
               $display("FAIL tone_na_early: got %b want 0", na0);
            else n_pass++;
         end
         if (k == 3) begin
            n_total++;
            if ({na0, idx0} !== 3'b101)
               $display("FAIL tone_pick: got %b want 101", {na0, idx0});
            else n_pass++;
         end
         e = (k >= 20 && k <= 27) || (k >= 36 && k <= 43);
         n_total++;
         if (amp0.AIN !== e)
            $display("FAIL tone_ain k=%0d: got %b want %b",
               k, amp0.AIN, e);
         else n_pass++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if ({amp0.AIN, na0, amp0.SHUTDOWN_L} !== 3'b001)
         $display("FAIL mid_reset: got %b want 001",
            {amp0.AIN, na0, amp0.SHUTDOWN_L});
      else n_pass++;
   endtask

   task automatic test_hold_vs_priority();
      logic e;
      do_reset();
      keys   = 4'b0010;
      volume = 4'd15;
      for (int k = 1; k <= 96; k++) begin
         @(negedge clk);
         if (k == 41 || k == 42) begin
            n_total++;
            e = (k == 41);
            if ({na1, idx1} !== {1'b1, 1'b0, e})
               $display("FAIL prio_idx k=%0d: got %b want 10%b",
                  k, {na1, idx1}, e);
            else n_pass++;
         end
         if (k == 59 || k == 62) begin
            n_total++;
            if ({na0, idx0} !== 3'b101)
               $display("FAIL hold_idx k=%0d: got %b want 101",
                  k, {na0, idx0});
            else n_pass++;
         end
         if (k == 63) begin
            n_total++;
            if (na0 !== 1'b0)
               $display("FAIL hold_gap: got %b want 0", na0);
            else n_pass++;
         end
         if (k == 64) begin
            n_total++;
            if ({na0, idx0} !== 3'b100)
               $display("FAIL hold_repick: got %b want 100",
                  {na0, idx0});
            else n_pass++;
         end
         if (k >= 65 && k <= 95) begin
            e = (k <= 74) || (k >= 85 && k <= 94);
            n_total++;
            if (amp0.AIN !== e)
               $display("FAIL hold_ain k=%0d: got %b want %b",
                  k, amp0.AIN, e);
            else n_pass++;
         end
         if (k >= 43 && k <= 82) begin
            e = (k <= 52 && k != 48) ||
                (k >= 63 && k <= 72 && k != 64);
            n_total++;
            if (amp1.AIN !== e)
               $display("FAIL prio_ain k=%0d: got %b want %b",
                  k, amp1.AIN, e);
            else n_pass++;
         end
         if (k == 90) begin
            n_total++;
            if ({na1, idx1} !== 3'b100)
               $display("FAIL prio_keep: got %b want 100",
                  {na1, idx1});
            else n_pass++;
         end
         if (k == 39) keys = 4'b0011;
         if (k == 60) keys = 4'b0001;
      end
   endtask

   task automatic test_release();
      logic e;
      do_reset();
      keys   = 4'b0010;
      volume = 4'd15;
      for (int k = 1; k <= 85; k++) begin
         @(negedge clk);
         e = (k >= 20 && k <= 27) || (k >= 36 && k <= 43) ||
             (k >= 52 && k <= 56);
         n_total++;
         if (amp0.AIN !== e)
            $display("FAIL rel_ain k=%0d: got %b want %b",
               k, amp0.AIN, e);
         else n_pass++;
         if (k == 42 || k == 43 || k == 82 || k == 83) begin
            e = (k == 42 || k == 83);
            n_total++;
            if (na0 !== e)
               $display("FAIL rel_na k=%0d: got %b want %b",
                  k, na0, e);
            else n_pass++;
         end
         if (k == 72 || k == 73 || k == 82 || k == 83) begin
            e = (k == 72 || k == 83);
            n_total++;
            if (amp0.SHUTDOWN_L !== e)
               $display("FAIL rel_shdn k=%0d: got %b want %b",
                  k, amp0.SHUTDOWN_L, e);
            else n_pass++;
         end
         if (k == 83) begin
            n_total++;
            if (idx0 !== 2'd2)
               $display("FAIL rel_idx: got %0d want 2", idx0);
            else n_pass++;
         end
         if (k == 40) keys = 4'b0000;
         if (k == 80) keys = 4'b0100;
      end
   endtask

   task automatic test_env_off();
      logic e;
      do_reset();
      keys   = 4'b0010;
      volume = 4'd15;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         e = (k >= 5 && k <= 11) || (k >= 20 && k <= 27) ||
             k == 36 || k == 52;
         n_total++;
         if (amp2.AIN !== e)
            $display("FAIL envoff_ain k=%0d: got %b want %b",
               k, amp2.AIN, e);
         else n_pass++;
         if (k == 3 || k == 70) begin
            n_total++;
            if ({na2, idx2} !== 3'b101)
               $display("FAIL envoff_note k=%0d: got %b want 101",
                  k, {na2, idx2});
            else n_pass++;
         end
         if (k == 30) volume = 4'd4;
         if (k == 60) volume = 4'd0;
      end
   endtask

   initial begin
      test_reset();
      test_tone_env();
      test_hold_vs_priority();
      test_release();
      test_env_off();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
